// File: rtl/csc_pkg.sv
// Shared constants, Q8 coefficients and the shift/clamp helper for the
// colour-space converter pipeline.
package csc_pkg;

   localparam int CSC_FRAC      = 8;
   localparam int CSC_COEF_W    = 11;
   localparam int CSC_MAX_DW    = 12;
   localparam int CSC_ACC_MAX_W = CSC_MAX_DW + CSC_FRAC + 4;

   localparam logic [1:0] CSC_YUV2RGB = 2'd0;
   localparam logic [1:0] CSC_RGB2YUV = 2'd1;
   localparam logic [1:0] CSC_BYPASS  = 2'd2;

   typedef logic signed [CSC_COEF_W-1:0] coef_t;

   localparam coef_t CSC_K_ZERO  = 11'sd0;
   localparam coef_t CSC_K_UNITY = 11'sd256;

   // YUV->RGB, BT.601 full range; luma carries the unity (pre-scaled) term
   localparam coef_t CSC_K_RV = 11'sd359;
   localparam coef_t CSC_K_GU = -11'sd88;
   localparam coef_t CSC_K_GV = -11'sd183;
   localparam coef_t CSC_K_BU = 11'sd454;

   localparam coef_t CSC_K_YR = 11'sd77;
   localparam coef_t CSC_K_YG = 11'sd150;
   localparam coef_t CSC_K_YB = 11'sd29;
   localparam coef_t CSC_K_UR = -11'sd43;
   localparam coef_t CSC_K_UG = -11'sd85;
   localparam coef_t CSC_K_UB = 11'sd128;
   localparam coef_t CSC_K_VR = 11'sd128;
   localparam coef_t CSC_K_VG = -11'sd107;
   localparam coef_t CSC_K_VB = -11'sd21;

   typedef struct packed {
      logic [CSC_MAX_DW-1:0] val;
      logic                  clip;
   } csc_clamp_t;

   // acc already contains the +0.5 rounding term; shift drops the fraction
   function automatic csc_clamp_t csc_round_clamp(
      input logic signed [CSC_ACC_MAX_W-1:0] acc,
      input int                              dw
   );
      logic signed [CSC_ACC_MAX_W-1:0] sh;
      logic signed [CSC_ACC_MAX_W-1:0] maxv;
      csc_clamp_t                      res;
      sh   = acc >>> CSC_FRAC;
      maxv = CSC_ACC_MAX_W'((1 << dw) - 1);
      res  = '0;
      if (sh[CSC_ACC_MAX_W-1]) begin
         res.clip = 1'b1;
      end else if (sh > maxv) begin
         res.val  = maxv[CSC_MAX_DW-1:0];
         res.clip = 1'b1;
      end else begin
         res.val  = sh[CSC_MAX_DW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/csc_mac3.sv
// One output row: registered products (S1), then their sum plus offset and
// rounding term (S2). Pure datapath, advanced by the shared pipeline enable.
module csc_mac3
   import csc_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = DW + CSC_FRAC + 4
) (
   input  logic                 clk,
   input  logic                 en,
   input  coef_t                k0,
   input  coef_t                k1,
   input  coef_t                k2,
   input  logic signed [DW:0]   a0,
   input  logic signed [DW:0]   a1,
   input  logic signed [DW:0]   a2,
   input  logic signed [AW-1:0] off,
   output logic signed [AW-1:0] acc_p2
);

   localparam logic signed [AW-1:0] RND = AW'(1 << (CSC_FRAC - 1));

   logic signed [AW-1:0] prod0_p1_q, prod0_p1_d;
   logic signed [AW-1:0] prod1_p1_q, prod1_p1_d;
   logic signed [AW-1:0] prod2_p1_q, prod2_p1_d;
   logic signed [AW-1:0] off_p1_q, off_p1_d;
   logic signed [AW-1:0] acc_p2_q, acc_p2_d;

   always_comb begin
      prod0_p1_d = prod0_p1_q;
      prod1_p1_d = prod1_p1_q;
      prod2_p1_d = prod2_p1_q;
      off_p1_d   = off_p1_q;
      acc_p2_d   = acc_p2_q;
      if (en) begin
         // S1: coefficient x operand products
         prod0_p1_d = AW'(k0) * AW'(a0);
         prod1_p1_d = AW'(k1) * AW'(a1);
         prod2_p1_d = AW'(k2) * AW'(a2);
         off_p1_d   = off;
         // S2: row sum with offset and half-LSB rounding
         acc_p2_d   = prod0_p1_q + prod1_p1_q + prod2_p1_q + off_p1_q + RND;
      end
   end

   always_ff @(posedge clk) begin
      prod0_p1_q <= prod0_p1_d;
      prod1_p1_q <= prod1_p1_d;
      prod2_p1_q <= prod2_p1_d;
      off_p1_q   <= off_p1_d;
      acc_p2_q   <= acc_p2_d;
   end

   assign acc_p2 = acc_p2_q;

endmodule

// File: rtl/csc_pipe.sv
// Three-stage colour-space converter (YUV<->RGB, bypass) with a global
// valid/ready stall and a saturating clip-event counter.
module csc_pipe
   import csc_pkg::*;
#(
   parameter int DW   = 8,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_mode,
   input  logic [DW-1:0]   in_c0,
   input  logic [DW-1:0]   in_c1,
   input  logic [DW-1:0]   in_c2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_c0,
   output logic [DW-1:0]   out_c1,
   output logic [DW-1:0]   out_c2,
   output logic            out_clip,
   output logic [CNTW-1:0] clip_cnt,
   input  logic            clip_clr
);

   localparam int AW = DW + CSC_FRAC + 4;
   localparam logic signed [DW:0]   H     = (DW+1)'(1 << (DW - 1));
   localparam logic signed [AW-1:0] OFF_H = AW'((1 << (DW - 1)) << CSC_FRAC);

   logic                 adv;
   logic                 vld_p1_q, vld_p1_d;
   logic                 vld_p2_q, vld_p2_d;
   logic                 out_valid_q, out_valid_d;
   logic                 byp_p1_q, byp_p1_d;
   logic                 byp_p2_q, byp_p2_d;
   logic [DW-1:0]        out_c0_q, out_c0_d;
   logic [DW-1:0]        out_c1_q, out_c1_d;
   logic [DW-1:0]        out_c2_q, out_c2_d;
   logic                 out_clip_q, out_clip_d;
   logic [CNTW-1:0]      clip_cnt_q, clip_cnt_d;

   logic signed [DW:0]   a0, a1, a2;
   coef_t                k_row   [3][3];
   logic signed [AW-1:0] off_row [3];
   logic signed [AW-1:0] acc_p2  [3];
   csc_clamp_t           cl      [3];

   assign adv      = !out_valid_q | out_ready;
   assign in_ready = adv;

   // Operand and coefficient selection; the whole row set follows the pixel's own mode
   always_comb begin
      a0      = {1'b0, in_c0};
      a1      = {1'b0, in_c1};
      a2      = {1'b0, in_c2};
      k_row   = '{default: CSC_K_ZERO};
      off_row = '{default: '0};
      case (in_mode)
         CSC_YUV2RGB: begin
            a1       = {1'b0, in_c1} - H;
            a2       = {1'b0, in_c2} - H;
            k_row[0] = '{CSC_K_UNITY, CSC_K_ZERO, CSC_K_RV};
            k_row[1] = '{CSC_K_UNITY, CSC_K_GU,   CSC_K_GV};
            k_row[2] = '{CSC_K_UNITY, CSC_K_BU,   CSC_K_ZERO};
         end
         CSC_RGB2YUV: begin
            k_row[0]   = '{CSC_K_YR, CSC_K_YG, CSC_K_YB};
            k_row[1]   = '{CSC_K_UR, CSC_K_UG, CSC_K_UB};
            k_row[2]   = '{CSC_K_VR, CSC_K_VG, CSC_K_VB};
            off_row[1] = OFF_H;
            off_row[2] = OFF_H;
         end
         default: begin
            k_row[0] = '{CSC_K_UNITY, CSC_K_ZERO,  CSC_K_ZERO};
            k_row[1] = '{CSC_K_ZERO,  CSC_K_UNITY, CSC_K_ZERO};
            k_row[2] = '{CSC_K_ZERO,  CSC_K_ZERO,  CSC_K_UNITY};
         end
      endcase
   end

   for (genvar r = 0; r < 3; r++) begin : g_row
      csc_mac3 #(
         .DW (DW),
         .AW (AW)
      ) u_mac (
         .clk    (clk),
         .en     (adv),
         .k0     (k_row[r][0]),
         .k1     (k_row[r][1]),
         .k2     (k_row[r][2]),
         .a0     (a0),
         .a1     (a1),
         .a2     (a2),
         .off    (off_row[r]),
         .acc_p2 (acc_p2[r])
      );
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         cl[r] = csc_round_clamp(CSC_ACC_MAX_W'(acc_p2[r]), DW);
      end
   end

   always_comb begin
      vld_p1_d    = vld_p1_q;
      vld_p2_d    = vld_p2_q;
      out_valid_d = out_valid_q;
      byp_p1_d    = byp_p1_q;
      byp_p2_d    = byp_p2_q;
      out_c0_d    = out_c0_q;
      out_c1_d    = out_c1_q;
      out_c2_d    = out_c2_q;
      out_clip_d  = out_clip_q;
      if (adv) begin
         vld_p1_d    = in_valid;
         byp_p1_d    = in_mode[1];
         vld_p2_d    = vld_p1_q;
         byp_p2_d    = byp_p1_q;
         // S3: rounded, clamped result
         out_valid_d = vld_p2_q;
         out_c0_d    = cl[0].val[DW-1:0];
         out_c1_d    = cl[1].val[DW-1:0];
         out_c2_d    = cl[2].val[DW-1:0];
         out_clip_d  = vld_p2_q & ~byp_p2_q & (cl[0].clip | cl[1].clip | cl[2].clip);
      end
   end

   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (clip_clr) begin
         clip_cnt_d = '0;
      end else if (out_valid_q & out_ready & out_clip_q & ~&clip_cnt_q) begin
         clip_cnt_d = clip_cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_c0_q    <= '0;
         out_c1_q    <= '0;
         out_c2_q    <= '0;
         out_clip_q  <= 1'b0;
         clip_cnt_q  <= '0;
      end else begin
         vld_p1_q    <= vld_p1_d;
         vld_p2_q    <= vld_p2_d;
         out_valid_q <= out_valid_d;
         out_c0_q    <= out_c0_d;
         out_c1_q    <= out_c1_d;
         out_c2_q    <= out_c2_d;
         out_clip_q  <= out_clip_d;
         clip_cnt_q  <= clip_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      byp_p1_q <= byp_p1_d;
      byp_p2_q <= byp_p2_d;
   end

   assign out_valid = out_valid_q;
   assign out_c0    = out_c0_q;
   assign out_c1    = out_c1_q;
   assign out_c2    = out_c2_q;
   assign out_clip  = out_clip_q;
   assign clip_cnt  = clip_cnt_q;

endmodule

// File: doc/csc_pipe.md
Name: csc_pipe

Overview:
- Parametrised, pipelined colour-space converter. Successor to the fixed 8-bit YUV→RGB block.
- Per-pixel runtime mode: YUV→RGB (BT.601 full range), RGB→YUV, or bypass.
- Uses a valid/ready handshake with backpressure and provides a saturating clip-event counter.
- Sits between the camera/decoder stream and the display/processing stream in the video pipeline.

Parameters:
- DW, 8: bits per colour component (range 8..12).
- CNTW, 16: width of the clip-event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_mode  in  2  per-pixel mode: 0 YUV→RGB, 1 RGB→YUV, 2/3 bypass.
- in_c0, in_c1, in_c2  in  DW each  input components: Y,U,V (mode 0) or R,G,B (mode 1).
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- out_c0, out_c1, out_c2  out  DW each  output components: R,G,B or Y,U,V.
- out_clip  out  1  at least one component of this output pixel was clamped.
- clip_cnt  out  CNTW  number of clamped output pixels; saturates at all-ones.
- clip_clr  in  1  synchronous clear of clip_cnt.

Behaviour:
- Reset values: out_valid=0; out_c0..out_c2=0; out_clip=0; clip_cnt=0; all internal stage valids=0.
- in_ready is high during reset release once rst=1.
- Pipeline has 3 stages:
  - S1 registers the centred inputs and the products.
  - S2 registers the sums plus rounding offset.
  - S3 registers the rounded, clamped result.
- Latency is 3 accepted cycles from input handshake to out_valid when there is no stall.
- Global stall rule: adv = !out_valid | out_ready. All stages load only when adv=1. in_ready = adv (combinational).
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- A bubble enters S1 when adv=1 and in_valid=0. Bubbles travel down and collapse naturally.
- Outputs hold stable while out_valid=1 and out_ready=0.
- The mode travels with each pixel, so a mix of modes back to back is legal.
- Constants: H = 2^(DW-1); MAX = 2^DW-1; FRAC = 8. Coefficients are signed Q8.
- Mode 0 (YUV→RGB), with u = U−H and v = V−H:
  - R = Y + (359v)/256
  - G = Y − (88u + 183v)/256
  - B = Y + (454u)/256
- Mode 1 (RGB→YUV):
  - Y = (77R + 150G + 29B)/256
  - U = (−43R − 85G + 128B)/256 + H
  - V = (128R − 107G − 21B)/256 + H
- Arithmetic:
  - All signed, accumulator width DW+FRAC+4.
  - Luma/offset terms are pre-scaled by 256.
  - Add 128 before an arithmetic shift right by 8 (round half-up).
  - Clamp: result < 0 → 0; result > MAX → MAX. out_clip = OR of the three clamp events.
- Bypass: inputs are copied unchanged through the same 3-stage latency, with out_clip=0.
- clip_cnt increments by 1 on each output transfer with out_clip=1. It holds at all-ones.
- clip_clr has priority over an increment in the same cycle; the result is 0.
- Reset mid-stream discards all in-flight pixels, with no partial output.

Decomposition:
- Package csc_pkg holds:
  - Q8 coefficient localparams for both matrices.
  - FRAC=8 and the mode encoding constants (CSC_YUV2RGB, CSC_RGB2YUV, CSC_BYPASS).
  - A function for round-shift-clamp(acc, DW) returning the value plus a clip flag.
- Sub-module csc_mac3 is a natural split: a one-row, 3-term signed MAC with offset, instantiated 3×.

Test Plan:
- DW=8, mode0, YUV=(128,128,128) → RGB=(128,128,128) after 3 cycles, clip=0.
- Mode0, YUV=(255,128,255) → RGB=(255,164,255), clip=1, clip_cnt=1.
- Mode0, YUV=(0,128,0) → RGB=(0,92,0), clip=1. Then mode1, RGB=(255,255,255) → YUV=(255,128,128), clip=0.
- Stream 10 pixels with out_ready toggled 1,0,0,1,…:
  - No pixel lost or duplicated.
  - Outputs stable while stalled.
  - in_ready equals !out_valid|out_ready every cycle.
- Alternating modes 0/1/2 per pixel, back to back → each output matches the golden model for its own mode. Bypass outputs equal their inputs.
- clip_cnt forced to reach all-ones with CNTW=4 → holds at 15. clip_clr together with a clip transfer → 0.
- Assert rst with 3 pixels in flight → out_valid=0 immediately, and no stale pixel is emitted after release.
